// File: rtl/stack_sequencer.sv
// Stack sequencer: turns pre-decoded push/pop masks into a series of 16-bit
// stack bus cycles at SS:SP. Pushes go lowest bit first; pops go highest bit first.
module stack_sequencer #(
  parameter int MASK_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MASK_W-1:0] push_mask,
  input  logic [MASK_W-1:0] pop_mask,
  input  logic [15:0]       sp_in,
  input  logic [15:0]       operand_in,
  output logic [3:0]        reg_sel,
  input  logic [15:0]       reg_value,
  output logic              wr_en,
  output logic [3:0]        wr_sel,
  output logic [15:0]       wr_data,
  output logic [15:0]       operand_out,
  output logic              sp_we,
  output logic [15:0]       sp_out,
  output logic              bus_req,
  output logic              bus_write,
  output logic [15:0]       bus_addr,
  output logic [15:0]       bus_wdata,
  input  logic [15:0]       bus_rdata,
  input  logic              bus_ack,
  output logic              busy,
  output logic              done
);

  localparam logic [3:0]        SP_BIT      = 4'd4;
  localparam logic [3:0]        DISCARD_BIT = 4'd5;
  localparam logic [3:0]        OPERAND_BIT = 4'(MASK_W - 1);
  localparam logic [MASK_W-1:0] PUSH_KEEP   = ~(MASK_W'(1) << DISCARD_BIT);

  typedef enum logic [1:0] {IDLE, PUSH, POP, FINISH} state_t;

  state_t            state, state_next;
  logic [MASK_W-1:0] push_rem, pop_rem, push_after, pop_after;
  logic [15:0]       wsp, orig_sp, operand_lat;
  logic [3:0]        push_idx, pop_idx;
  logic              pop_discard;

  function automatic logic [3:0] lowest_set(input logic [MASK_W-1:0] m);
    logic [3:0] idx;
    idx = '0;
    for (int i = MASK_W - 1; i >= 0; i--) if (m[i]) idx = 4'(i);
    return idx;
  endfunction

  function automatic logic [3:0] highest_set(input logic [MASK_W-1:0] m);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MASK_W; i++) if (m[i]) idx = 4'(i);
    return idx;
  endfunction

  assign push_idx    = lowest_set(push_rem);
  assign pop_idx     = highest_set(pop_rem);
  assign push_after  = push_rem & ~(MASK_W'(1) << push_idx);
  assign pop_after   = pop_rem & ~(MASK_W'(1) << pop_idx);
  assign pop_discard = (pop_idx == SP_BIT) || (pop_idx == DISCARD_BIT);
  assign sp_out      = wsp;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      push_rem    <= '0;
      pop_rem     <= '0;
      wsp         <= '0;
      orig_sp     <= '0;
      operand_lat <= '0;
      operand_out <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) begin
          push_rem    <= push_mask & PUSH_KEEP;
          pop_rem     <= pop_mask;
          wsp         <= sp_in;
          orig_sp     <= sp_in;
          operand_lat <= operand_in;
        end
        PUSH: if (bus_ack) begin
          wsp      <= wsp - 16'd2;
          push_rem <= push_after;
        end
        POP: if (bus_ack) begin
          wsp     <= wsp + 16'd2;
          pop_rem <= pop_after;
          if (pop_idx == OPERAND_BIT) operand_out <= bus_rdata;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next = state;
    reg_sel    = '0;
    wr_en      = 1'b0;
    wr_sel     = '0;
    wr_data    = '0;
    sp_we      = 1'b0;
    bus_req    = 1'b0;
    bus_write  = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) begin
        if ((push_mask & PUSH_KEEP) != '0) state_next = PUSH;
        else if (pop_mask != '0)           state_next = POP;
        else                               state_next = FINISH;
      end
      PUSH: begin
        busy      = 1'b1;
        bus_req   = 1'b1;
        bus_write = 1'b1;
        bus_addr  = wsp - 16'd2;
        reg_sel   = push_idx;
        if (push_idx == SP_BIT)           bus_wdata = orig_sp;
        else if (push_idx == OPERAND_BIT) bus_wdata = operand_lat;
        else                              bus_wdata = reg_value;
        if (bus_ack && push_after == '0)
          state_next = (pop_rem != '0) ? POP : FINISH;
      end
      POP: begin
        busy     = 1'b1;
        bus_req  = 1'b1;
        bus_addr = wsp;
        // Discard slots and the operand slot never touch the register file.
        if (bus_ack && !pop_discard && pop_idx != OPERAND_BIT) begin
          wr_en   = 1'b1;
          wr_sel  = pop_idx;
          wr_data = bus_rdata;
        end
        if (bus_ack && pop_after == '0) state_next = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        sp_we      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: table of transactions, a bus/memory
// responder with configurable wait states, and scoreboards for bus cycles and pops.
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] push_mask, pop_mask, sp_in, operand_in;
  logic [3:0]  reg_sel;
  logic [15:0] reg_value;
  logic        wr_en;
  logic [3:0]  wr_sel;
  logic [15:0] wr_data, operand_out;
  logic        sp_we;
  logic [15:0] sp_out;
  logic        bus_req, bus_write;
  logic [15:0] bus_addr, bus_wdata;
  logic [15:0] bus_rdata;
  logic        bus_ack;
  logic        busy, done;

  stack_sequencer #(.MASK_W(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .push_mask(push_mask), .pop_mask(pop_mask),
    .sp_in(sp_in), .operand_in(operand_in),
    .reg_sel(reg_sel), .reg_value(reg_value),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .operand_out(operand_out), .sp_we(sp_we), .sp_out(sp_out),
    .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] data;
  } wr_exp_t;

  typedef struct {
    string       name;
    logic [15:0] push;
    logic [15:0] pop;
    logic [15:0] sp;
    logic [15:0] op;
    int          waits;
    bit          inject;
    logic [15:0] exp_sp;
    int          exp_lat;
    int          exp_slots;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  bus_exp_t    exp_bus[$];
  wr_exp_t     exp_wr[$];
  vec_t        vecs[$];
  logic [15:0] regs [16];
  logic [15:0] mem [65536];
  logic [15:0] exp_mem [65536];
  logic [15:0] exp_operand;
  int          cur_waits = 0;
  int          wait_cnt = 0;
  bit          stray_ack = 0;
  int          ack_count = 0;
  int          req_count = 0;
  logic        h_write;
  logic [15:0] h_addr, h_wdata;

  assign reg_value = regs[reg_sel];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Bus responder and monitor: ack decided at negedge, outputs sampled 1ns later.
  always @(negedge clk) begin
    bus_ack = 1'b0;
    if (bus_req) begin
      if (wait_cnt == 0) begin
        h_write = bus_write; h_addr = bus_addr; h_wdata = bus_wdata;
      end else begin
        check("stable_write", {31'd0, bus_write}, {31'd0, h_write});
        check("stable_addr", {16'd0, bus_addr}, {16'd0, h_addr});
        if (h_write) check("stable_wdata", {16'd0, bus_wdata}, {16'd0, h_wdata});
      end
      if (wait_cnt >= cur_waits) begin
        bus_ack   = 1'b1;
        bus_rdata = mem[bus_addr];
        if (bus_write) mem[bus_addr] = bus_wdata;
        wait_cnt  = 0;
      end else begin
        bus_rdata = 16'hxxxx;
        wait_cnt++;
      end
    end else begin
      wait_cnt  = 0;
      bus_ack   = stray_ack;
      bus_rdata = 16'hDEAD;
    end
    #1;
    if (bus_req) req_count++;
    if (bus_req && bus_ack) begin
      ack_count++;
      if (exp_bus.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_bus_cycle: addr 0x%0h write %0b, want no cycle", bus_addr, bus_write);
      end else begin
        bus_exp_t e;
        e = exp_bus.pop_front();
        check("bus_write", {31'd0, bus_write}, {31'd0, e.write});
        check("bus_addr", {16'd0, bus_addr}, {16'd0, e.addr});
        if (e.write) check("bus_wdata", {16'd0, bus_wdata}, {16'd0, e.wdata});
      end
    end
    if (wr_en) begin
      if (exp_wr.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_wr_en: sel %0d data 0x%0h, want no write", wr_sel, wr_data);
      end else begin
        wr_exp_t r;
        r = exp_wr.pop_front();
        check("wr_sel", {28'd0, wr_sel}, {28'd0, r.sel});
        check("wr_data", {16'd0, wr_data}, {16'd0, r.data});
      end
    end
  end

  // Reference model: pushes lowest bit first (slot 5 skipped), pops highest first.
  task automatic model_txn(input logic [15:0] pm, input logic [15:0] pp,
                           input logic [15:0] sp, input logic [15:0] op);
    logic [15:0] w;
    bus_exp_t    b;
    wr_exp_t     r;
    w = sp;
    for (int i = 0; i < 16; i++) begin
      if (pm[i] && i != 5) begin
        w       = w - 16'd2;
        b.write = 1'b1;
        b.addr  = w;
        b.wdata = (i == 4) ? sp : (i == 15) ? op : regs[i];
        exp_bus.push_back(b);
        exp_mem[w] = b.wdata;
      end
    end
    for (int i = 15; i >= 0; i--) begin
      if (pp[i]) begin
        b.write = 1'b0;
        b.addr  = w;
        b.wdata = 16'd0;
        exp_bus.push_back(b);
        if (i == 15) exp_operand = exp_mem[w];
        else if (i != 4 && i != 5) begin
          r.sel  = 4'(i);
          r.data = exp_mem[w];
          exp_wr.push_back(r);
        end
        w = w + 16'd2;
      end
    end
  endtask

  task automatic run_txn(input vec_t v);
    int lat;
    bit seen;
    int acks0, reqs0;
    model_txn(v.push, v.pop, v.sp, v.op);
    cur_waits = v.waits;
    @(negedge clk);
    acks0 = ack_count;
    reqs0 = req_count;
    start = 1'b1; push_mask = v.push; pop_mask = v.pop; sp_in = v.sp; operand_in = v.op;
    lat = 0; seen = 0;
    while (!seen && lat < 500) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (v.inject && lat == 2) begin
        start = 1'b1; push_mask = 16'h0001; pop_mask = 16'h0001; sp_in = 16'h5555;
      end
      #2;
      if (done) seen = 1;
    end
    start = 1'b0;
    if (!seen) check({"timeout_", v.name}, 32'd0, 32'd1);
    check({"latency_", v.name}, lat, v.exp_lat);
    check({"sp_we_", v.name}, {31'd0, sp_we}, 32'd1);
    check({"sp_out_", v.name}, {16'd0, sp_out}, {16'd0, v.exp_sp});
    check({"busy_at_done_", v.name}, {31'd0, busy}, 32'd0);
    @(negedge clk); #2;
    check({"done_pulse_", v.name}, {31'd0, done}, 32'd0);
    check({"busy_after_", v.name}, {31'd0, busy}, 32'd0);
    check({"acks_", v.name}, ack_count - acks0, v.exp_slots);
    check({"req_cycles_", v.name}, req_count - reqs0, v.exp_slots * (v.waits + 1));
    check({"bus_left_", v.name}, exp_bus.size(), 32'd0);
    check({"wr_left_", v.name}, exp_wr.size(), 32'd0);
    check({"operand_out_", v.name}, {16'd0, operand_out}, {16'd0, exp_operand});
    exp_bus.delete();
    exp_wr.delete();
  endtask

  task automatic add_vec(input string name, input logic [15:0] pm, input logic [15:0] pp,
                         input logic [15:0] sp, input logic [15:0] op, input int waits,
                         input bit inject, input logic [15:0] exp_sp, input int exp_lat,
                         input int exp_slots);
    vec_t v;
    v.name = name; v.push = pm; v.pop = pp; v.sp = sp; v.op = op; v.waits = waits;
    v.inject = inject; v.exp_sp = exp_sp; v.exp_lat = exp_lat; v.exp_slots = exp_slots;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t post;
    reset = 1'b1; start = 1'b0; push_mask = '0; pop_mask = '0; sp_in = '0; operand_in = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    exp_operand = 16'd0;
    for (int i = 0; i < 16; i++) regs[i] = 16'hA000 | 16'(i);
    regs[10] = 16'hF002; regs[11] = 16'h1234; regs[14] = 16'h0056;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'(i * 3 + 7);
      exp_mem[i] = 16'(i * 3 + 7);
    end

    //      name              push      pop       sp        operand   w  inj exp_sp    lat slots
    add_vec("push_psw_ps_pc", 16'h4C00, 16'h0000, 16'h0100, 16'h0000, 0, 0, 16'h00FA, 4,  3);
    add_vec("pop_pc_ps_psw",  16'h0000, 16'h4C00, 16'h00FA, 16'h0000, 2, 0, 16'h0100, 10, 3);
    add_vec("push_r",         16'h01DF, 16'h0000, 16'h0200, 16'h0000, 0, 0, 16'h01F0, 9,  8);
    add_vec("pop_r",          16'h0000, 16'h01EF, 16'h01F0, 16'h0000, 1, 0, 16'h0200, 17, 8);
    add_vec("push_operand",   16'h8000, 16'h0000, 16'h0000, 16'hBEEF, 0, 0, 16'hFFFE, 2,  1);
    add_vec("pop_operand",    16'h0000, 16'h8000, 16'hFFFE, 16'h0000, 0, 0, 16'h0000, 2,  1);
    add_vec("empty_masks",    16'h0000, 16'h0000, 16'h1357, 16'h0000, 0, 0, 16'h1357, 1,  0);
    add_vec("start_busy",     16'h4C00, 16'h0000, 16'h3000, 16'h0000, 1, 1, 16'h2FFA, 7,  3);
    add_vec("start_finish",   16'h0001, 16'h0000, 16'h4000, 16'h0000, 0, 1, 16'h3FFE, 2,  1);
    add_vec("push_then_pop",  16'h0003, 16'h0003, 16'h0010, 16'h0000, 0, 0, 16'h0010, 5,  4);
    add_vec("push_discard",   16'h0020, 16'h0000, 16'h0777, 16'h0000, 0, 0, 16'h0777, 1,  0);
    add_vec("pop_sp_discard", 16'h0000, 16'h0010, 16'h0100, 16'h0000, 0, 0, 16'h0102, 2,  1);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #2;
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sp_we", {31'd0, sp_we}, 32'd0);
    check("rst_sp_out", {16'd0, sp_out}, 32'd0);
    check("rst_reg_sel", {28'd0, reg_sel}, 32'd0);
    check("rst_operand_out", {16'd0, operand_out}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Acks while no request is outstanding must be ignored.
    stray_ack = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      check("stray_busy", {31'd0, busy}, 32'd0);
      check("stray_done", {31'd0, done}, 32'd0);
    end
    stray_ack = 0;

    // Reset in the middle of a waited push abandons the cycle immediately.
    cur_waits = 3;
    @(negedge clk);
    start = 1'b1; push_mask = 16'h4C00; pop_mask = 16'h0000; sp_in = 16'h0500;
    @(negedge clk);
    start = 1'b0;
    #2;
    check("pre_reset_bus_req", {31'd0, bus_req}, 32'd1);
    @(negedge clk); #3;
    reset = 1'b1;
    #1;
    check("mid_reset_bus_req", {31'd0, bus_req}, 32'd0);
    check("mid_reset_busy", {31'd0, busy}, 32'd0);
    check("mid_reset_done", {31'd0, done}, 32'd0);
    check("mid_reset_operand_out", {16'd0, operand_out}, 32'd0);
    check("mid_reset_sp_out", {16'd0, sp_out}, 32'd0);
    exp_bus.delete();
    exp_wr.delete();
    exp_operand = 16'd0;
    repeat (2) @(negedge clk);
    #3 reset = 1'b0;

    post.name = "after_reset"; post.push = 16'h4C00; post.pop = 16'h0000; post.sp = 16'h0500;
    post.op = 16'h0000; post.waits = 0; post.inject = 0; post.exp_sp = 16'h04FA;
    post.exp_lat = 4; post.exp_slots = 3;
    run_txn(post);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, want completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Executes the stack push/pop masks that pre-decode emits (pre_decode_t.push / .pop, STACK_* bit layout) as a series of 16-bit stack bus cycles at SS:SP.
- Push side writes registers to memory; pop side reads memory back into registers.
- Sits between the execute stage, the register file and the bus interface unit. Used by PUSH/POP, PUSH R/POP R, CALL/RET, and interrupt entry and RETI.

Parameters:
- MASK_W, 16, width of push/pop masks; bit positions match STACK_* constants.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- push_mask  in  16  STACK_* bits to push
- pop_mask  in  16  STACK_* bits to pop
- sp_in  in  16  current SP, sampled on start
- operand_in  in  16  value for STACK_OPERAND push, sampled on start
- reg_sel  out  4  bit index of register being pushed; regfile returns its value combinationally
- reg_value  in  16  value of register reg_sel, same cycle
- wr_en  out  1  register write strobe (pop)
- wr_sel  out  4  bit index of register written
- wr_data  out  16  popped data
- operand_out  out  16  data popped for STACK_OPERAND
- sp_we  out  1  one-cycle SP writeback strobe
- sp_out  out  16  final SP
- bus_req  out  1  stack bus cycle request
- bus_write  out  1  1=write (push), 0=read (pop)
- bus_addr  out  16  SS-relative offset
- bus_wdata  out  16  write data
- bus_rdata  in  16  read data, valid with bus_ack
- bus_ack  in  1  cycle completion
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE. All outputs 0, including sp_out, operand_out and reg_sel. An in-flight cycle is abandoned; bus_req drops in the same cycle reset asserts.
- States: IDLE, PUSH, POP, FINISH.
- Start handling:
  - start in IDLE latches the masks, sp_in and operand_in into a working SP (wsp) and sets busy.
  - Next state: PUSH if the effective push mask != 0, else POP if pop mask != 0, else FINISH.
  - start while busy is ignored.
- Effective masks:
  - Push: bit 5 (SP_DISCARD) is cleared.
  - Pop: bits 4 (SP) and 5 (SP_DISCARD) are both discard slots. They generate a read cycle and SP += 2, but no register write.
- PUSH:
  - Order is lowest set bit first, i.e. AW..IY, DS1, PSW, PS, SS, DS0, PC, OPERAND.
  - Per slot: bus_req=1, bus_write=1, bus_addr=wsp-2, reg_sel=bit index. bus_wdata=reg_value, except bit 4 uses the latched sp_in (original SP) and bit 15 uses the latched operand_in.
  - Outputs hold stable until bus_ack. On ack: wsp -= 2, clear the bit; bus_req may stay high for the next slot, which is issued the following cycle.
  - When no bits remain: go to POP if the pop mask != 0, else FINISH.
- POP:
  - Order is highest set bit first (OPERAND, PC, DS0, ... AW), so it mirrors push.
  - Per slot: bus_req=1, bus_write=0, bus_addr=wsp.
  - On bus_ack:
    - wsp += 2; clear the bit.
    - For non-discard bits other than 15: wr_en=1 for that cycle, wr_sel=bit index, wr_data=bus_rdata.
    - For bit 15: operand_out <= bus_rdata; no wr_en.
  - When no bits remain: go to FINISH.
- FINISH (one cycle):
  - done=1, sp_we=1, sp_out=wsp, busy=0. Return to IDLE.
  - A new start in that same cycle is ignored; it is accepted from the next cycle.
- Timing:
  - Minimum latency is start -> first bus_req 1 cycle.
  - N cycles with zero-wait ack give done at start+N+1.
  - Empty masks give done at start+1, with sp_out=sp_in and no bus activity.
- Arithmetic: wsp is 16-bit modulo.
  - Push at SP=0x0000 writes 0xFFFE.
  - Pop at SP=0xFFFE reads 0xFFFE and ends at 0x0000.
- Both masks nonzero: all pushes complete before any pop.
- bus_ack while bus_req=0 is ignored.

Test Plan:
- Push of PSW|PS|PC (0x4C00): sp_in=0x0100, PSW=0xF002, PS=0x1234, PC=0x0056, 0 wait -> writes 0x00FE=F002, 0x00FC=1234, 0x00FA=0056; done at start+4; sp_out=0x00FA.
- Pop of PC|PS|PSW (0x4C00) at sp=0x00FA, memory as above, 2-wait ack -> wr_sel 14,11,10 with 0x0056, 0x1234, 0xF002 in that order; sp_out=0x0100; bus outputs stable across waits.
- PUSH R (0x01DF) at SP=0x0200 -> 8 writes, slot 4 carries 0x0200. Then POP R (0x01EF) -> 8 reads, no wr_en for slot 5; final SP=0x0200.
- Operand round trip: push 0x8000 with operand_in=0xBEEF at SP=0x0000 -> write to 0xFFFE. Then pop 0x8000 -> operand_out=0xBEEF, sp_out=0x0000.
- Empty masks -> done and sp_we at start+1, sp_out=sp_in, bus_req never asserted. start asserted during busy -> ignored, no extra bus cycles.
- Reset asserted while bus_req=1 mid-push -> bus_req, busy and done drop immediately. After release, a new start executes normally from IDLE.
